// File: rtl/truth_table_prober.sv
// Truth-table prober: walks a 3-input gate through vectors 000..111 and reads back its 8-bit code.
// Optional glitch detection (second sample per vector) is enabled by defining TT_GLITCH_CHECK_EN.
module truth_table_prober #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [2:0] probe_in,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt_code,
`ifdef TT_GLITCH_CHECK_EN
  output logic [7:0] unstable_mask,
`endif
  output logic [1:0] o_dbg_state
);

  // Handshake: start is a level sampled only in IDLE; done pulses for one cycle with tt_code valid.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETTLE = 2'd1, S_DONE = 2'd2} state_t;

`ifdef TT_GLITCH_CHECK_EN
  if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be 2..255 when glitch checking is enabled");
  end
`else
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be 1..255");
  end
`endif

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_idx;
  logic [7:0] r_cnt;
  logic [7:0] r_shadow;
  logic [7:0] r_tt_code;
  logic       w_last;
  logic [7:0] w_shadow_nxt;

  assign w_last = (r_cnt == CNT_LAST);

  always_comb begin
    w_next   = r_state;
    probe_in = 3'd0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        busy     = 1'b1;
        probe_in = r_idx;
        if (w_last && r_idx == 3'd7) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Final sample merged in so tt_code can load on the same edge that enters DONE.
  always_comb begin
    w_shadow_nxt = r_shadow;
    w_shadow_nxt[3'd7 - r_idx] = dut_out;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= 3'd0;
      r_cnt     <= 8'd0;
      r_shadow  <= 8'd0;
      r_tt_code <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx    <= 3'd0;
            r_cnt    <= 8'd0;
            r_shadow <= 8'd0;
          end
        end
        S_SETTLE: begin
          if (w_last) begin
            r_shadow <= w_shadow_nxt;
            r_cnt    <= 8'd0;
            if (r_idx == 3'd7) r_tt_code <= w_shadow_nxt;
            else               r_idx     <= r_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TT_GLITCH_CHECK_EN
  localparam logic [7:0] CNT_EARLY = 8'(SETTLE_CYCLES - 2);

  logic       r_early;
  logic [7:0] r_umask_sh;
  logic [7:0] r_umask;
  logic [7:0] w_umask_nxt;

  always_comb begin
    w_umask_nxt = r_umask_sh;
    w_umask_nxt[3'd7 - r_idx] = r_early ^ dut_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_early    <= 1'b0;
      r_umask_sh <= 8'd0;
      r_umask    <= 8'd0;
    end else if (r_state == S_IDLE && start) begin
      r_umask_sh <= 8'd0;
    end else if (r_state == S_SETTLE) begin
      if (r_cnt == CNT_EARLY) r_early <= dut_out;
      if (w_last) begin
        r_umask_sh <= w_umask_nxt;
        if (r_idx == 3'd7) r_umask <= w_umask_nxt;
      end
    end
  end

  assign unstable_mask = r_umask;
`endif

  assign tt_code     = r_tt_code;
  assign o_dbg_state = r_state;

endmodule
